cim_xbar_tile: RTL and testbench
================================

CIM_XBAR_TILE -- requirements
Module: cim_xbar_tile

Interface
REQ-001 SHALL have parameter xbar_size, default 128, meaning crossbar rows = columns.
REQ-002 SHALL have parameter datatype_size, default 4, meaning input/weight/output element width.
REQ-003 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: i_we  input  1  input-vector write strobe.
REQ-006 SHALL have port: i_wr_addr  input  $clog2(xbar_size)  input-vector row index.
REQ-007 SHALL have port: i_wr_data  input  datatype_size  input-vector element.
REQ-008 SHALL have port: i_w_we  input  1  weight write strobe.
REQ-009 SHALL have ports: i_w_row, i_w_col  input  $clog2(xbar_size) each  weight cell address.
REQ-010 SHALL have port: i_w_data  input  datatype_size  weight value.
REQ-011 SHALL have port: i_start  input  1  MVM request pulse.
REQ-012 SHALL have port: o_busy  output  1  tile computing; drives the layer's i_cim_busy.
REQ-013 SHALL have port: i_rd_addr  input  $clog2(xbar_size)  result column select.
REQ-014 SHALL have port: o_data  output  datatype_size  registered result of selected column.

Function
REQ-015 SHALL hold an xbar_size-entry input buffer, an xbar_size x xbar_size weight array, xbar_size accumulators, and xbar_size result registers; all values unsigned.
REQ-016 SHALL implement states IDLE, COMPUTE, DONE: IDLE->COMPUTE on i_start; COMPUTE->DONE after row counter reaches xbar_size-1; DONE->IDLE unconditionally.
REQ-017 SHALL, on the i_start edge in IDLE, clear all accumulators and the row counter, and assert o_busy starting the next cycle.
REQ-018 SHALL, in COMPUTE, add in[r]*w[r][c] to acc[c] for every column c in parallel, with r = row counter, one row per cycle, counter incrementing by 1.
REQ-019 SHALL size each accumulator at 2*datatype_size+$clog2(xbar_size) bits so no overflow occurs.
REQ-020 SHALL, in DONE, load result[c] = min(acc[c], 2^datatype_size-1) (saturation, not truncation).
REQ-021 SHALL keep o_busy high during COMPUTE and DONE: exactly xbar_size+1 cycles per operation; low in IDLE.
REQ-022 SHALL drive o_data <= result[i_rd_addr] every cycle (1-cycle read latency, valid in any state; reflects previous results until DONE commits).
REQ-023 SHALL write i_wr_data to in[i_wr_addr] when i_we high and state is IDLE; SHALL ignore i_we otherwise.
REQ-024 SHALL write i_w_data to w[i_w_row][i_w_col] when i_w_we high and state is IDLE; SHALL ignore otherwise.
REQ-025 SHALL ignore i_start while busy (no restart, no queuing).
REQ-026 SHALL, when i_we and i_start coincide in IDLE, commit the write and include it in the computation started.
REQ-027 SHALL leave input buffer and weights unchanged by a completed operation (back-to-back starts reuse them).

Reset
REQ-028 SHALL, on rst low, immediately clear state to IDLE, o_busy to 0, o_data to 0, row counter, accumulators, result registers, input buffer and weights to 0.
REQ-029 SHALL abort a COMPUTE in progress on reset; no partial results are committed.
REQ-030 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Verification (xbar_size=4, datatype_size=4)
REQ-031 Identity: w[i][i]=1, others 0; in={3,5,7,9}; pulse i_start -> o_busy high exactly 5 cycles; then i_rd_addr 0..3 -> o_data 3,5,7,9 one cycle after each address.
REQ-032 Saturation: all w=15, in={15,15,15,15} -> every column result 15; w col0 all 1, in={1,2,3,4} -> result[0]=10 unsaturated.
REQ-033 Busy rejection: i_we to row 0 value 8 and i_start during COMPUTE -> buffer unchanged, o_busy falls after the original 5 cycles, no second operation.
REQ-034 Simultaneous write+start in IDLE with in[2]<=6, w[2][1]=2, all others 0 -> result[1]=12.
REQ-035 Reset mid-COMPUTE (cycle 2): o_busy and o_data 0 asynchronously; after release, reading any column gives 0.
REQ-036 Back-to-back: second i_start the cycle after o_busy falls -> identical results, o_busy high again 5 cycles.

Source files
------------

// File: rtl/cim_xbar_tile.sv
// Compute-in-memory crossbar tile: buffers an input vector and a weight matrix,
// then runs one row per cycle into per-column accumulators and saturates the results.
module cim_xbar_tile #(
    parameter int xbar_size     = 128,
    parameter int datatype_size = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_we,
    input  logic [$clog2(xbar_size)-1:0] i_wr_addr,
    input  logic [datatype_size-1:0]     i_wr_data,
    input  logic                         i_w_we,
    input  logic [$clog2(xbar_size)-1:0] i_w_row,
    input  logic [$clog2(xbar_size)-1:0] i_w_col,
    input  logic [datatype_size-1:0]     i_w_data,
    input  logic                         i_start,
    output logic                         o_busy,
    input  logic [$clog2(xbar_size)-1:0] i_rd_addr,
    output logic [datatype_size-1:0]     o_data
);

    localparam int AW    = $clog2(xbar_size);
    localparam int ACC_W = 2 * datatype_size + AW;
    localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W - datatype_size){1'b0}}, {datatype_size{1'b1}}};

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                   state, state_nxt;
    logic [AW-1:0]            row;
    logic                     last_row;
    logic [datatype_size-1:0] in_buf [xbar_size];
    logic [datatype_size-1:0] w_arr  [xbar_size][xbar_size];
    logic [ACC_W-1:0]         acc    [xbar_size];
    logic [datatype_size-1:0] result [xbar_size];

    function automatic logic [datatype_size-1:0] sat_result(input logic [ACC_W-1:0] a);
        if (a > SAT_MAX)
            return '1;
        return a[datatype_size-1:0];
    endfunction

    assign last_row = (row == AW'(xbar_size - 1));
    assign o_busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = COMPUTE;
            COMPUTE: if (last_row) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Storage is writable only while idle, so an operation always sees a stable operand set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < xbar_size; r++) begin
                in_buf[r] <= '0;
                for (int c = 0; c < xbar_size; c++)
                    w_arr[r][c] <= '0;
            end
        end else if (state == IDLE) begin
            if (i_we)
                in_buf[i_wr_addr] <= i_wr_data;
            if (i_w_we)
                w_arr[i_w_row][i_w_col] <= i_w_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            for (int c = 0; c < xbar_size; c++) begin
                acc[c]    <= '0;
                result[c] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        row <= '0;
                        for (int c = 0; c < xbar_size; c++)
                            acc[c] <= '0;
                    end
                end
                COMPUTE: begin
                    row <= row + 1'b1;
                    for (int c = 0; c < xbar_size; c++)
                        acc[c] <= acc[c] + ACC_W'(in_buf[row]) * ACC_W'(w_arr[row][c]);
                end
                DONE: begin
                    for (int c = 0; c < xbar_size; c++)
                        result[c] <= sat_result(acc[c]);
                end
                default: ;
            endcase
        end
    end

    // Read port is independent of the FSM; it shows old results until DONE commits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            o_data <= '0;
        else
            o_data <= result[i_rd_addr];
    end

endmodule

// File: tb/tb_cim_xbar_tile.sv
// Bench for cim_xbar_tile (4x4, 4-bit): directed scenarios plus randomized operations,
// checked each cycle against a vector-level model of the tile.
module tb_cim_xbar_tile;

    localparam int N = 4;
    localparam int D = 4;
    localparam int MAXV = (1 << D) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_we = 1'b0;
    logic [1:0]   i_wr_addr = '0;
    logic [D-1:0] i_wr_data = '0;
    logic         i_w_we = 1'b0;
    logic [1:0]   i_w_row = '0;
    logic [1:0]   i_w_col = '0;
    logic [D-1:0] i_w_data = '0;
    logic         i_start = 1'b0;
    logic         o_busy;
    logic [1:0]   i_rd_addr = '0;
    logic [D-1:0] o_data;

    cim_xbar_tile #(.xbar_size(N), .datatype_size(D)) dut (
        .clk(clk), .rst(rst),
        .i_we(i_we), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_w_we(i_w_we), .i_w_row(i_w_row), .i_w_col(i_w_col), .i_w_data(i_w_data),
        .i_start(i_start), .o_busy(o_busy),
        .i_rd_addr(i_rd_addr), .o_data(o_data)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Vector-level model: an operation is a matrix-vector product that becomes visible
    // N+1 cycles after the start is accepted.
    int in_m [N];
    int w_m  [N][N];
    int res_m[N];
    int pend [N];
    int busy_cnt = 0;
    int exp_odata = 0;

    function automatic int mvm_col(input int c);
        int s = 0;
        for (int r = 0; r < N; r++)
            s += in_m[r] * w_m[r][c];
        return (s > MAXV) ? MAXV : s;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < N; r++) begin
                in_m[r] = 0;
                res_m[r] = 0;
                pend[r] = 0;
                for (int c = 0; c < N; c++)
                    w_m[r][c] = 0;
            end
            busy_cnt = 0;
            exp_odata = 0;
        end else begin
            exp_odata = res_m[i_rd_addr];
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0)
                    for (int c = 0; c < N; c++)
                        res_m[c] = pend[c];
            end else begin
                if (i_we)
                    in_m[i_wr_addr] = int'(i_wr_data);
                if (i_w_we)
                    w_m[i_w_row][i_w_col] = int'(i_w_data);
                if (i_start) begin
                    for (int c = 0; c < N; c++)
                        pend[c] = mvm_col(c);
                    busy_cnt = N + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("busy", {31'b0, o_busy}, {31'b0, busy_cnt > 0});
            check("o_data", {28'b0, o_data}, exp_odata);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr_in(input int a, input int v);
        i_wr_addr = a[1:0];
        i_wr_data = v[D-1:0];
        i_we = 1'b1;
        step();
        i_we = 1'b0;
    endtask

    task automatic wr_w(input int r, input int c, input int v);
        i_w_row = r[1:0];
        i_w_col = c[1:0];
        i_w_data = v[D-1:0];
        i_w_we = 1'b1;
        step();
        i_w_we = 1'b0;
    endtask

    task automatic fill_w(input int v);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                wr_w(r, c, v);
    endtask

    task automatic run_op(input bit noisy, output int cycles);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        cycles = 0;
        while (o_busy && cycles < 20) begin
            if (noisy) begin
                i_rd_addr = 2'($urandom_range(0, N - 1));
                i_we      = 1'($urandom);
                i_wr_addr = 2'($urandom);
                i_wr_data = 4'($urandom);
                i_w_we    = 1'($urandom);
                i_w_row   = 2'($urandom);
                i_w_col   = 2'($urandom);
                i_w_data  = 4'($urandom);
                i_start   = 1'($urandom);
            end
            cycles++;
            step();
        end
        i_we = 1'b0;
        i_w_we = 1'b0;
        i_start = 1'b0;
    endtask

    task automatic rd_chk(input string name, input int a, input int e);
        i_rd_addr = a[1:0];
        step();
        check(name, {28'b0, o_data}, e);
    endtask

    int cyc;
    int ident_exp[N] = '{3, 5, 7, 9};

    initial begin
        #1;
        check("reset_busy", {31'b0, o_busy}, 0);
        check("reset_data", {28'b0, o_data}, 0);
        #20;
        @(posedge clk);
        #2 rst = 1'b1;
        step();

        // Identity matrix passes the input vector straight through.
        for (int i = 0; i < N; i++) wr_w(i, i, 1);
        for (int i = 0; i < N; i++) wr_in(i, ident_exp[i]);
        run_op(1'b0, cyc);
        check("ident_busy_cycles", cyc, N + 1);
        for (int i = 0; i < N; i++) rd_chk("ident_rd", i, ident_exp[i]);

        // Write and start during COMPUTE are ignored.
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        cyc = 0;
        while (o_busy && cyc < 20) begin
            if (cyc == 1) begin
                i_we = 1'b1; i_wr_addr = 2'd0; i_wr_data = 4'd8; i_start = 1'b1;
            end else begin
                i_we = 1'b0; i_start = 1'b0;
            end
            cyc++;
            step();
        end
        i_we = 1'b0;
        i_start = 1'b0;
        check("reject_busy_cycles", cyc, N + 1);
        for (int k = 0; k < 3; k++) begin
            check("reject_no_restart", {31'b0, o_busy}, 0);
            step();
        end
        run_op(1'b0, cyc);
        rd_chk("reject_buf_kept", 0, 3);

        // Back-to-back: second start on the cycle after busy drops.
        run_op(1'b0, cyc);
        check("b2b_first_cycles", cyc, N + 1);
        run_op(1'b0, cyc);
        check("b2b_second_cycles", cyc, N + 1);
        for (int i = 0; i < N; i++) rd_chk("b2b_rd", i, ident_exp[i]);

        // Saturation at the top of the range, then an unsaturated column sum.
        fill_w(15);
        for (int i = 0; i < N; i++) wr_in(i, 15);
        run_op(1'b0, cyc);
        for (int i = 0; i < N; i++) rd_chk("sat_rd", i, 15);
        for (int r = 0; r < N; r++) wr_w(r, 0, 1);
        for (int i = 0; i < N; i++) wr_in(i, i + 1);
        run_op(1'b0, cyc);
        rd_chk("unsat_col0", 0, 10);

        // Input write coinciding with start is part of that operation.
        fill_w(0);
        for (int i = 0; i < N; i++) wr_in(i, 0);
        wr_w(2, 1, 2);
        i_we = 1'b1; i_wr_addr = 2'd2; i_wr_data = 4'd6;
        run_op(1'b0, cyc);
        check("simul_busy_cycles", cyc, N + 1);
        rd_chk("simul_col1", 1, 12);
        rd_chk("simul_col0", 0, 0);

        // Asynchronous reset in the middle of COMPUTE.
        i_rd_addr = 2'd1;
        step();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        rst = 1'b0;
        #1;
        check("rst_busy", {31'b0, o_busy}, 0);
        check("rst_data", {28'b0, o_data}, 0);
        #10;
        @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < N; i++) rd_chk("rst_rd", i, 0);
        run_op(1'b0, cyc);
        rd_chk("rst_cleared_col1", 1, 0);

        // Randomized operations with stray traffic while busy.
        for (int it = 0; it < 8; it++) begin
            for (int r = 0; r < N; r++) begin
                wr_in(r, (it < 4) ? $urandom_range(0, 3) : $urandom_range(0, 15));
                for (int c = 0; c < N; c++)
                    wr_w(r, c, (it < 4) ? $urandom_range(0, 2) : $urandom_range(0, 15));
            end
            run_op(1'b1, cyc);
            check("rand_busy_cycles", cyc, N + 1);
            for (int i = 0; i < N; i++) rd_chk("rand_rd", i, res_m[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
